sampling_pool_layer: RTL and testbench
======================================

// Module: sampling_pool_layer
// PURPOSE
//  Parametrised 2x2/stride-2 subsampling (pooling) layer for the CNN datapath. Takes CHANNELS
//  parallel feature maps streamed in raster order, one pixel per channel per valid beat, and
//  emits one pooled pixel per channel per 2x2 window. Selectable max or average pooling.
//  Sits between a convolution layer and the next convolution layer; no backpressure.
// PARAMETERS
//  CHANNELS  6   number of parallel feature maps (>=1)
//  DATA_W    16  pixel width, signed two's complement (Q8.8 in this design)
//  IMG_W     28  input columns per row; must be even (elaboration-time $error otherwise)
//  IMG_H     28  input rows per frame; must be even (elaboration-time $error otherwise)
//  MODE      0   0 = max pooling, 1 = average pooling
// PORTS
//  Clock          in   1                  rising-edge clock
//  Input_Reset    in   1                  async active-high reset
//  Input_Valid    in   1                  one pixel per channel on Input_Pixel this cycle
//  Input_Finish   in   1                  end-of-frame / abort strobe
//  Input_Pixel    in   CHANNELS*DATA_W    channel c at [c*DATA_W +: DATA_W]
//  Output_Pixel   out  CHANNELS*DATA_W    pooled pixels, same packing
//  Output_Valid   out  1                  Output_Pixel carries a new pooled pixel
//  Output_Finish  out  1                  one-cycle pulse: frame complete
// BEHAVIOUR
//  - Reset (async assert, sync release): Output_Pixel=0, Output_Valid=0, Output_Finish=0,
//    col=0, row=0, held partials cleared. Line buffer need not be cleared (rewritten on even rows).
//  - Counters col (0..IMG_W-1), row (0..IMG_H-1) advance only on Input_Valid; col wraps to 0 and
//    row increments at col=IMG_W-1; row wraps to 0 after (IMG_H-1, IMG_W-1).
//  - Gaps in Input_Valid of any length are allowed; state holds.
//  - Per channel, op(a,b) = signed max(a,b) for MODE 0; a+b at DATA_W+2 bits for MODE 1.
//  - Even col: register pixel as horizontal partial h. Odd col: p = op(h, pixel).
//  - Even row, odd col: write p into line buffer entry col>>1 (IMG_W/2 entries per channel).
//  - Odd row, odd col: r = op(linebuf[col>>1], p). MODE 0: out = r. MODE 1: out = r>>>2
//    (arithmetic shift, floor toward -inf), truncated to DATA_W; no saturation needed.
//  - Latency: Output_Pixel/Output_Valid registered, valid exactly 1 cycle after the input beat at
//    (odd row, odd col). Output_Valid is a 1-cycle pulse per window; Output_Pixel holds its last
//    value otherwise. All channels produce output in the same cycle.
//  - Output count per full frame: (IMG_W/2)*(IMG_H/2) valid pulses.
//  - Output_Finish asserts in the same cycle as the Output_Valid of window (IMG_H-1, IMG_W-1).
//  - Input_Finish in a cycle not completing the frame: any coincident valid beat is processed
//    normally (may still produce its output), then col/row clear to 0 and partials are
//    discarded; Output_Finish pulses the next cycle (with that output if one was produced).
//  - Input_Finish coincident with the final beat (IMG_H-1, IMG_W-1): no extra pulse; single
//    Output_Finish as above.
//  - Input_Finish with counters already at 0 and no valid: Output_Finish still pulses once.
//  - Input_Reset mid-frame: immediate clear per reset values; any in-flight output is lost;
//    next valid beat is treated as pixel (0,0).
//  - Back-to-back frames: beat (0,0) of the next frame may arrive the cycle after the final beat.
// TESTING
//  1 MODE0, CHANNELS=2, IMG 4x4, ch0 pixels 0..15 raster, ch1 = -(ch0) -> ch0 outputs 5,7,13,15;
//    ch1 outputs 0,-2,-8,-10; Output_Valid 1 cycle after beats 5,7,13,15; Finish with last.
//  2 MODE1, IMG 4x4, window {-1,-2,-3,-4} -> -10>>>2 = -3 (0xFFFD); window {1,1,1,2} -> 1;
//    window {0x7FFF x4} -> 0x7FFF (no overflow).
//  3 IMG 28x28, Input_Valid random 50% duty -> exactly 196 valid pulses, values match model,
//    one Output_Finish; second frame back-to-back identical.
//  4 Input_Finish at beat (1,1) with valid, IMG 4x4 -> output for window 0 next cycle with
//    Output_Finish=1; following frame from (0,0) produces correct results.
//  5 Input_Reset asserted mid-row 2 between edges -> all outputs 0 immediately; restarted frame
//    correct; no stale Output_Valid.
//  6 CHANNELS=6 default params, distinct random data per channel -> per-channel match, no
//    cross-channel leakage.

Source files
------------

// File: rtl/sampling_pool_layer.sv
// 2x2 / stride-2 pooling layer for CHANNELS parallel raster-order feature maps.
// MODE 0 selects signed max pooling, and MODE 1 selects average pooling (floor of sum/4).
module sampling_pool_layer #(
    parameter int CHANNELS = 6,
    parameter int DATA_W   = 16,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int MODE     = 0
) (
    input  logic                         Clock,
    input  logic                         Input_Reset,
    input  logic                         Input_Valid,
    input  logic                         Input_Finish,
    input  logic [CHANNELS*DATA_W-1:0]   Input_Pixel,
    output logic [CHANNELS*DATA_W-1:0]   Output_Pixel,
    output logic                         Output_Valid,
    output logic                         Output_Finish
);

    localparam int PW     = DATA_W + 2;
    localparam int HALF   = IMG_W / 2;
    localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int COL_W  = HALF_W + 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    generate
        if ((IMG_W % 2) != 0) begin : g_badWidth
            $error("sampling_pool_layer: IMG_W must be even");
        end
        if ((IMG_H % 2) != 0) begin : g_badHeight
            $error("sampling_pool_layer: IMG_H must be even");
        end
    endgenerate

    logic [COL_W-1:0]         r_col;
    logic [ROW_W-1:0]         r_row;
    logic signed [PW-1:0]     r_h       [CHANNELS];
    logic signed [PW-1:0]     r_lineBuf [CHANNELS][HALF];
    logic [DATA_W-1:0]        r_out     [CHANNELS];
    logic                     r_outValid;
    logic                     r_outFinish;

    logic [HALF_W-1:0]        w_half;
    logic signed [PW-1:0]     w_pix [CHANNELS];
    logic signed [PW-1:0]     w_p   [CHANNELS];
    logic signed [PW-1:0]     w_r   [CHANNELS];
    logic [DATA_W-1:0]        w_out [CHANNELS];
    logic                     w_colLast;
    logic                     w_rowLast;
    logic                     w_frameLast;
    logic                     w_emit;
    logic                     w_store;

    // Partials carry two guard bits so a four-pixel sum cannot overflow.
    function automatic logic signed [PW-1:0] poolOp(input logic signed [PW-1:0] a,
                                                    input logic signed [PW-1:0] b);
        if (MODE == 0) begin
            return (a > b) ? a : b;
        end else begin
            return a + b;
        end
    endfunction

    assign w_half      = r_col[COL_W-1:1];
    assign w_colLast   = (r_col == COL_W'(IMG_W - 1));
    assign w_rowLast   = (r_row == ROW_W'(IMG_H - 1));
    assign w_frameLast = Input_Valid && w_colLast && w_rowLast;
    assign w_emit      = Input_Valid && r_row[0] && r_col[0];
    assign w_store     = Input_Valid && !r_row[0] && r_col[0];

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_pix[c] = PW'($signed(Input_Pixel[c*DATA_W +: DATA_W]));
            w_p[c]   = poolOp(r_h[c], w_pix[c]);
            w_r[c]   = poolOp(r_lineBuf[c][w_half], w_p[c]);
            if (MODE == 0) begin
                w_out[c] = DATA_W'(w_r[c]);
            end else begin
                w_out[c] = DATA_W'(w_r[c] >>> 2);
            end
        end
    end

    always_comb begin
        Output_Pixel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            Output_Pixel[c*DATA_W +: DATA_W] = r_out[c];
        end
    end

    assign Output_Valid  = r_outValid;
    assign Output_Finish = r_outFinish;

    // The line buffer is rewritten on every even row before it is read, so it needs no reset.
    always_ff @(posedge Clock) begin
        if (w_store) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_lineBuf[c][w_half] <= w_p[c];
            end
        end
    end

    always_ff @(posedge Clock or posedge Input_Reset) begin
        if (Input_Reset) begin
            r_col       <= '0;
            r_row       <= '0;
            r_outValid  <= 1'b0;
            r_outFinish <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_h[c]   <= '0;
                r_out[c] <= '0;
            end
        end else begin
            r_outValid  <= w_emit;
            r_outFinish <= Input_Finish || w_frameLast;
            for (int c = 0; c < CHANNELS; c++) begin
                if (Input_Valid && !r_col[0]) begin
                    r_h[c] <= w_pix[c];
                end
                if (w_emit) begin
                    r_out[c] <= w_out[c];
                end
            end
            // An abort still lets the coincident beat emit, then restarts the frame.
            if (Input_Finish) begin
                r_col <= '0;
                r_row <= '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    r_h[c] <= '0;
                end
            end else if (Input_Valid) begin
                if (w_colLast) begin
                    r_col <= '0;
                    r_row <= w_rowLast ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sampling_pool_layer.sv
// Directed bench for sampling_pool_layer: max/average 4x4 frames, abort, reset, and a 6-channel 28x28 stream.
// Expected values are computed from the input pattern by a small reference model in this bench.
module tb_sampling_pool_layer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        aValid = 1'b0, aFinish = 1'b0, aOutValid, aOutFinish;
    logic [31:0] aPixIn = '0, aPixOut;
    logic        bValid = 1'b0, bFinish = 1'b0, bOutValid, bOutFinish;
    logic [31:0] bPixIn = '0, bPixOut;
    logic        cValid = 1'b0, cFinish = 1'b0, cOutValid, cOutFinish;
    logic [95:0] cPixIn = '0, cPixOut;

    int passCount  = 0;
    int checkCount = 0;

    sampling_pool_layer #(.CHANNELS(2), .DATA_W(16), .IMG_W(4), .IMG_H(4), .MODE(0)) dutA (
        .Clock(clk), .Input_Reset(rst), .Input_Valid(aValid), .Input_Finish(aFinish),
        .Input_Pixel(aPixIn), .Output_Pixel(aPixOut), .Output_Valid(aOutValid),
        .Output_Finish(aOutFinish));

    sampling_pool_layer #(.CHANNELS(2), .DATA_W(16), .IMG_W(4), .IMG_H(4), .MODE(1)) dutB (
        .Clock(clk), .Input_Reset(rst), .Input_Valid(bValid), .Input_Finish(bFinish),
        .Input_Pixel(bPixIn), .Output_Pixel(bPixOut), .Output_Valid(bOutValid),
        .Output_Finish(bOutFinish));

    sampling_pool_layer dutC (
        .Clock(clk), .Input_Reset(rst), .Input_Valid(cValid), .Input_Finish(cFinish),
        .Input_Pixel(cPixIn), .Output_Pixel(cPixOut), .Output_Valid(cOutValid),
        .Output_Finish(cOutFinish));

    // Inputs change 1 time unit after the rising edge, and outputs are sampled at that same point.
    task automatic stepA(input logic v, input logic f, input int p0, input int p1);
        aValid = v; aFinish = f; aPixIn = {16'(p1), 16'(p0)};
        @(posedge clk); #1;
        aValid = 1'b0; aFinish = 1'b0;
    endtask

    task automatic stepB(input logic v, input int p0, input int p1);
        bValid = v; bPixIn = {16'(p1), 16'(p0)};
        @(posedge clk); #1;
        bValid = 1'b0;
    endtask

    function automatic logic signed [15:0] pixC(input int c, input int r, input int col, input int f);
        int v;
        v = (r * 28 + col + 1) * 40503 + c * 9973 + f * 7777;
        v = v ^ (v >>> 9);
        return 16'(v);
    endfunction

    function automatic logic signed [15:0] max4(input logic signed [15:0] a, input logic signed [15:0] b,
                                                input logic signed [15:0] c, input logic signed [15:0] d);
        logic signed [15:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checkCount++;
        if (aPixOut !== '0 || aOutValid !== 1'b0 || aOutFinish !== 1'b0) $display("[TB] FAIL reset_A pix=%h v=%b f=%b want 0", aPixOut, aOutValid, aOutFinish);
        else passCount++;
        checkCount++;
        if (bPixOut !== '0 || bOutValid !== 1'b0 || bOutFinish !== 1'b0) $display("[TB] FAIL reset_B pix=%h v=%b f=%b want 0", bPixOut, bOutValid, bOutFinish);
        else passCount++;
        checkCount++;
        if (cPixOut !== '0 || cOutValid !== 1'b0 || cOutFinish !== 1'b0) $display("[TB] FAIL reset_C pix=%h v=%b f=%b want 0", cPixOut, cOutValid, cOutFinish);
        else passCount++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // ch0 = raster index, ch1 = its negation; the max of each window is its bottom-right (ch0) or top-left (ch1) pixel.
    task automatic test_max_pool(input string tag);
        logic expV, expF;
        logic [15:0] exp0, exp1;
        for (int i = 0; i < 16; i++) begin
            stepA(1'b1, 1'b0, i, -i);
            expV = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            expF = (i == 15);
            checkCount++;
            if (aOutValid !== expV) $display("[TB] FAIL %s valid beat %0d got %b want %b", tag, i, aOutValid, expV);
            else passCount++;
            checkCount++;
            if (aOutFinish !== expF) $display("[TB] FAIL %s finish beat %0d got %b want %b", tag, i, aOutFinish, expF);
            else passCount++;
            if (expV) begin
                exp0 = 16'(i);
                exp1 = 16'(-(i - 5));
                checkCount++;
                if (aPixOut !== {exp1, exp0}) $display("[TB] FAIL %s pixel beat %0d got %h want %h", tag, i, aPixOut, {exp1, exp0});
                else passCount++;
            end
        end
        stepA(1'b0, 1'b0, 99, 99);
        checkCount++;
        if (aOutValid !== 1'b0 || aOutFinish !== 1'b0 || aPixOut !== {16'hFFF6, 16'h000F})
            $display("[TB] FAIL %s idle_hold got v=%b f=%b pix=%h want 0 0 fff6000f", tag, aOutValid, aOutFinish, aPixOut);
        else passCount++;
    endtask

    task automatic test_avg_pool();
        int inTab [16] = '{-1, -2, 1, 1, -3, -4, 1, 2, 32767, 32767, -1, 0, 32767, 32767, 0, 0};
        logic [15:0] exp0 [4] = '{16'hFFFD, 16'h0001, 16'h7FFF, 16'hFFFF};
        logic [15:0] exp1 [4] = '{16'h0002, 16'hFFFE, 16'h8001, 16'h0000};
        int k;
        logic expV;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            stepB(1'b1, inTab[i], -inTab[i]);
            expV = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            checkCount++;
            if (bOutValid !== expV) $display("[TB] FAIL avg valid beat %0d got %b want %b", i, bOutValid, expV);
            else passCount++;
            if (expV) begin
                checkCount++;
                if (bPixOut !== {exp1[k], exp0[k]}) $display("[TB] FAIL avg window %0d got %h want %h", k, bPixOut, {exp1[k], exp0[k]});
                else passCount++;
                checkCount++;
                if (bOutFinish !== (k == 3)) $display("[TB] FAIL avg finish window %0d got %b want %b", k, bOutFinish, (k == 3));
                else passCount++;
                k++;
            end
        end
    endtask

    task automatic test_finish_abort();
        for (int i = 0; i < 6; i++) begin
            stepA(1'b1, (i == 5), i, -i);
            checkCount++;
            if (aOutValid !== (i == 5) || aOutFinish !== (i == 5))
                $display("[TB] FAIL abort beat %0d got v=%b f=%b want %b %b", i, aOutValid, aOutFinish, (i == 5), (i == 5));
            else passCount++;
        end
        checkCount++;
        if (aPixOut !== {16'h0000, 16'h0005}) $display("[TB] FAIL abort_pixel got %h want 00000005", aPixOut);
        else passCount++;
        stepA(1'b0, 1'b0, 0, 0);
        checkCount++;
        if (aOutValid !== 1'b0 || aOutFinish !== 1'b0) $display("[TB] FAIL abort_after got v=%b f=%b want 0 0", aOutValid, aOutFinish);
        else passCount++;
    endtask

    task automatic test_finish_idle();
        stepA(1'b0, 1'b1, 0, 0);
        checkCount++;
        if (aOutFinish !== 1'b1 || aOutValid !== 1'b0) $display("[TB] FAIL idle_finish got f=%b v=%b want 1 0", aOutFinish, aOutValid);
        else passCount++;
        stepA(1'b0, 1'b0, 0, 0);
        checkCount++;
        if (aOutFinish !== 1'b0) $display("[TB] FAIL idle_finish_pulse got f=%b want 0", aOutFinish);
        else passCount++;
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 10; i++) stepA(1'b1, 1'b0, i, -i);
        checkCount++;
        if (aPixOut !== {16'hFFFE, 16'h0007}) $display("[TB] FAIL pre_reset_pixel got %h want fffe0007", aPixOut);
        else passCount++;
        #2 rst = 1'b1;
        #1;
        checkCount++;
        if (aPixOut !== '0 || aOutValid !== 1'b0 || aOutFinish !== 1'b0)
            $display("[TB] FAIL midframe_reset got pix=%h v=%b f=%b want 0", aPixOut, aOutValid, aOutFinish);
        else passCount++;
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Two back-to-back 28x28 frames on six channels with random idle gaps between beats.
    task automatic test_stream_c();
        int pulses, finishes;
        logic expV, expF;
        logic signed [15:0] expPix;
        for (int f = 0; f < 2; f++) begin
            pulses = 0;
            finishes = 0;
            for (int r = 0; r < 28; r++) begin
                for (int col = 0; col < 28; col++) begin
                    if (!(f == 1 && r == 0 && col == 0)) begin
                        while ($urandom_range(0, 1) == 1) begin
                            cValid = 1'b0;
                            @(posedge clk); #1;
                            checkCount++;
                            if (cOutValid !== 1'b0 || cOutFinish !== 1'b0) $display("[TB] FAIL stream_gap frame %0d got v=%b f=%b want 0 0", f, cOutValid, cOutFinish);
                            else passCount++;
                        end
                    end
                    for (int ch = 0; ch < 6; ch++) cPixIn[ch*16 +: 16] = pixC(ch, r, col, f);
                    cValid = 1'b1;
                    @(posedge clk); #1;
                    cValid = 1'b0;
                    expV = (r % 2 == 1) && (col % 2 == 1);
                    expF = (r == 27) && (col == 27);
                    if (cOutValid === 1'b1) pulses++;
                    if (cOutFinish === 1'b1) finishes++;
                    checkCount++;
                    if (cOutValid !== expV || cOutFinish !== expF)
                        $display("[TB] FAIL stream_flags f%0d (%0d,%0d) got v=%b fin=%b want %b %b", f, r, col, cOutValid, cOutFinish, expV, expF);
                    else passCount++;
                    if (expV) begin
                        for (int ch = 0; ch < 6; ch++) begin
                            expPix = max4(pixC(ch, r-1, col-1, f), pixC(ch, r-1, col, f), pixC(ch, r, col-1, f), pixC(ch, r, col, f));
                            checkCount++;
                            if (cPixOut[ch*16 +: 16] !== expPix)
                                $display("[TB] FAIL stream_pix f%0d (%0d,%0d) ch%0d got %h want %h", f, r, col, ch, cPixOut[ch*16 +: 16], expPix);
                            else passCount++;
                        end
                    end
                end
            end
            checkCount++;
            if (pulses != 196) $display("[TB] FAIL stream_count frame %0d got %0d want 196", f, pulses);
            else passCount++;
            checkCount++;
            if (finishes != 1) $display("[TB] FAIL stream_finish_count frame %0d got %0d want 1", f, finishes);
            else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_max_pool("max");
        test_avg_pool();
        test_finish_abort();
        test_max_pool("max_after_abort");
        test_finish_idle();
        test_reset_midframe();
        test_max_pool("max_after_reset");
        test_stream_c();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
